// File: rtl/cic_dec_ctrl_if.sv
// Sample/config handshake bundle between the CIC datapath side and the
// decimator sequencing controller.
interface cic_dec_ctrl_if #(
    parameter int RATIO_WIDTH = 5
);
    logic                   enable;
    logic [RATIO_WIDTH-1:0] cfg_ratio;
    logic                   cfg_load;
    logic                   in_valid;
    logic                   in_ready;
    logic                   integ_en;
    logic                   comb_en;
    logic [RATIO_WIDTH-1:0] dec_phase;
    logic                   out_valid;
    logic                   busy;
    logic                   cfg_err;

    modport master (
        output enable, cfg_ratio, cfg_load, in_valid,
        input  in_ready, integ_en, comb_en, dec_phase, out_valid, busy, cfg_err
    );

    modport slave (
        input  enable, cfg_ratio, cfg_load, in_valid,
        output in_ready, integ_en, comb_en, dec_phase, out_valid, busy, cfg_err
    );
endinterface

// File: rtl/cic_dec_ctrl.sv
// CIC decimator sequencer: integrator enables per accepted sample, comb enables
// once per R accepts, comb warm-up tracking and a frame-aligned ratio update.
module cic_dec_ctrl #(
    parameter int NUM_STAGES    = 3,
    parameter int RATIO_WIDTH   = 5,
    parameter int DEFAULT_RATIO = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    cic_dec_ctrl_if.slave   bus
);
    localparam int WARM_W = $clog2(NUM_STAGES + 1);
    localparam logic [WARM_W-1:0]      WARM_MAX   = WARM_W'(NUM_STAGES);
    localparam logic [WARM_W-1:0]      WARM_LAST  = WARM_W'(NUM_STAGES - 1);
    localparam logic [RATIO_WIDTH-1:0] MIN_RATIO  = RATIO_WIDTH'(2);
    localparam logic [RATIO_WIDTH-1:0] RESET_RATIO = RATIO_WIDTH'(DEFAULT_RATIO);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [RATIO_WIDTH-1:0] phase_reg, phase_next;
    logic [RATIO_WIDTH-1:0] shadow_reg, shadow_next;
    logic [RATIO_WIDTH-1:0] active_reg, active_next;
    logic [WARM_W-1:0]      warm_reg, warm_next;
    logic                   comb_en_reg, comb_en_next;
    logic                   comb_qual_reg, comb_qual_next;
    logic                   out_valid_reg, out_valid_next;
    logic                   busy_reg, busy_next;
    logic                   cfg_err_reg, cfg_err_next;

    logic in_ready;
    logic accept;
    logic warm_sat;
    logic last_of_frame;

    assign in_ready      = (state_reg != IDLE) && bus.enable;
    assign accept        = in_ready && bus.in_valid;
    assign warm_sat      = (warm_reg == WARM_MAX);
    // Active ratio is always >= 2, so R-1 cannot underflow.
    assign last_of_frame = (phase_reg == (active_reg - RATIO_WIDTH'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            shadow_reg    <= RESET_RATIO;
            active_reg    <= RESET_RATIO;
            warm_reg      <= '0;
            comb_en_reg   <= 1'b0;
            comb_qual_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            cfg_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            shadow_reg    <= shadow_next;
            active_reg    <= active_next;
            warm_reg      <= warm_next;
            comb_en_reg   <= comb_en_next;
            comb_qual_reg <= comb_qual_next;
            out_valid_reg <= out_valid_next;
            busy_reg      <= busy_next;
            cfg_err_reg   <= cfg_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        shadow_next    = shadow_reg;
        active_next    = active_reg;
        warm_next      = warm_reg;
        comb_en_next   = 1'b0;
        comb_qual_next = 1'b0;
        out_valid_next = comb_en_reg && comb_qual_reg;
        cfg_err_next   = 1'b0;

        // Shadow write is independent of state; a same-cycle wrap still sees the old shadow.
        if (bus.cfg_load) begin
            if (bus.cfg_ratio < MIN_RATIO) begin
                cfg_err_next = 1'b1;
            end else begin
                shadow_next = bus.cfg_ratio;
            end
        end

        case (state_reg)
            IDLE: begin
                out_valid_next = 1'b0;
                if (bus.enable) begin
                    state_next  = WARMUP;
                    active_next = shadow_reg;
                    phase_next  = '0;
                    warm_next   = '0;
                end
            end
            WARMUP, RUN: begin
                if (!bus.enable) begin
                    state_next     = IDLE;
                    phase_next     = '0;
                    warm_next      = '0;
                    out_valid_next = 1'b0;
                end else if (accept) begin
                    if (last_of_frame) begin
                        phase_next     = '0;
                        comb_en_next   = 1'b1;
                        comb_qual_next = warm_sat;
                        active_next    = shadow_reg;
                        if (!warm_sat) begin
                            warm_next = warm_reg + WARM_W'(1);
                        end
                        if ((state_reg == WARMUP) && (warm_reg == WARM_LAST)) begin
                            state_next = RUN;
                        end
                    end else begin
                        phase_next = phase_reg + RATIO_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                phase_next = '0;
                warm_next  = '0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign bus.in_ready  = in_ready;
    assign bus.integ_en  = accept;
    assign bus.comb_en   = comb_en_reg;
    assign bus.dec_phase = phase_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Directed bench for cic_dec_ctrl: vector table for start-up and config errors,
// then hand-written sequences for gaps, disable, ratio change and async reset.
module tb_cic_dec_ctrl;
    localparam int RW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cic_dec_ctrl_if #(.RATIO_WIDTH(RW)) bus ();

    cic_dec_ctrl #(
        .NUM_STAGES   (3),
        .RATIO_WIDTH  (RW),
        .DEFAULT_RATIO(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic          en;
        logic          iv;
        logic          ld;
        logic [RW-1:0] ratio;
        logic          rdy;
        logic          ie;
        logic          ce;
        logic [RW-1:0] ph;
        logic          ov;
        logic          bz;
        logic          er;
    } vec_t;

    localparam int NVEC = 35;
    vec_t tbl [NVEC];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic          s_rdy, s_ie, s_ce, s_ov, s_bz, s_er;
    logic [RW-1:0] s_ph;

    function automatic vec_t mk(input logic en, iv, ld, input int ratio,
                                input logic rdy, ie, ce, input int ph,
                                input logic ov, bz, er);
        vec_t v;
        v.en = en; v.iv = iv; v.ld = ld; v.ratio = RW'(ratio);
        v.rdy = rdy; v.ie = ie; v.ce = ce; v.ph = RW'(ph);
        v.ov = ov; v.bz = bz; v.er = er;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample at the falling edge, advance past the next rising edge.
    task automatic step(input logic en, iv, ld, input logic [RW-1:0] ratio);
        bus.enable    = en;
        bus.in_valid  = iv;
        bus.cfg_load  = ld;
        bus.cfg_ratio = ratio;
        @(negedge clk);
        s_rdy = bus.in_ready;
        s_ie  = bus.integ_en;
        s_ce  = bus.comb_en;
        s_ph  = bus.dec_phase;
        s_ov  = bus.out_valid;
        s_bz  = bus.busy;
        s_er  = bus.cfg_err;
        $display("[TB] cyc=%0d en=%b iv=%b ld=%b r=%0d | rdy=%b ie=%b ce=%b ph=%0d ov=%b bz=%b er=%b",
                 cyc, en, iv, ld, ratio, s_rdy, s_ie, s_ce, s_ph, s_ov, s_bz, s_er);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        int last_ce;
        int ie_cnt;
        int n_ce;
        logic          prev_iv;
        logic [RW-1:0] prev_ph;

        // Start-up from IDLE, R=4, continuous in_valid; then two rejected ratios.
        tbl[0]  = mk(1,1,0,0, 0,0,0,0, 0,0,0);
        tbl[1]  = mk(1,1,0,0, 1,1,0,0, 0,1,0);
        tbl[2]  = mk(1,1,0,0, 1,1,0,1, 0,1,0);
        tbl[3]  = mk(1,1,0,0, 1,1,0,2, 0,1,0);
        tbl[4]  = mk(1,1,0,0, 1,1,0,3, 0,1,0);
        tbl[5]  = mk(1,1,0,0, 1,1,1,0, 0,1,0);
        tbl[6]  = mk(1,1,0,0, 1,1,0,1, 0,1,0);
        tbl[7]  = mk(1,1,0,0, 1,1,0,2, 0,1,0);
        tbl[8]  = mk(1,1,0,0, 1,1,0,3, 0,1,0);
        tbl[9]  = mk(1,1,0,0, 1,1,1,0, 0,1,0);
        tbl[10] = mk(1,1,0,0, 1,1,0,1, 0,1,0);
        tbl[11] = mk(1,1,0,0, 1,1,0,2, 0,1,0);
        tbl[12] = mk(1,1,0,0, 1,1,0,3, 0,1,0);
        tbl[13] = mk(1,1,0,0, 1,1,1,0, 0,1,0);
        tbl[14] = mk(1,1,0,0, 1,1,0,1, 0,1,0);
        tbl[15] = mk(1,1,0,0, 1,1,0,2, 0,1,0);
        tbl[16] = mk(1,1,0,0, 1,1,0,3, 0,1,0);
        tbl[17] = mk(1,1,0,0, 1,1,1,0, 0,1,0);
        tbl[18] = mk(1,1,0,0, 1,1,0,1, 1,1,0);
        tbl[19] = mk(1,1,0,0, 1,1,0,2, 0,1,0);
        tbl[20] = mk(1,1,0,0, 1,1,0,3, 0,1,0);
        tbl[21] = mk(1,1,0,0, 1,1,1,0, 0,1,0);
        tbl[22] = mk(1,1,0,0, 1,1,0,1, 1,1,0);
        tbl[23] = mk(1,1,0,0, 1,1,0,2, 0,1,0);
        tbl[24] = mk(1,1,0,0, 1,1,0,3, 0,1,0);
        tbl[25] = mk(1,1,0,0, 1,1,1,0, 0,1,0);
        tbl[26] = mk(1,1,0,0, 1,1,0,1, 1,1,0);
        tbl[27] = mk(1,1,1,1, 1,1,0,2, 0,1,0);
        tbl[28] = mk(1,1,1,0, 1,1,0,3, 0,1,1);
        tbl[29] = mk(1,1,0,0, 1,1,1,0, 0,1,1);
        tbl[30] = mk(1,1,0,0, 1,1,0,1, 1,1,0);
        tbl[31] = mk(1,1,0,0, 1,1,0,2, 0,1,0);
        tbl[32] = mk(1,1,0,0, 1,1,0,3, 0,1,0);
        tbl[33] = mk(1,1,0,0, 1,1,1,0, 0,1,0);
        tbl[34] = mk(1,1,0,0, 1,1,0,1, 1,1,0);

        bus.enable = 1'b0; bus.in_valid = 1'b0; bus.cfg_load = 1'b0; bus.cfg_ratio = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",      bus.busy,      0);
        check("rst_comb_en",   bus.comb_en,   0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_phase",     bus.dec_phase, 0);
        check("rst_cfg_err",   bus.cfg_err,   0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].en, tbl[i].iv, tbl[i].ld, tbl[i].ratio);
            check($sformatf("tbl%0d_in_ready", i),  s_rdy, tbl[i].rdy);
            check($sformatf("tbl%0d_integ_en", i),  s_ie,  tbl[i].ie);
            check($sformatf("tbl%0d_comb_en", i),   s_ce,  tbl[i].ce);
            check($sformatf("tbl%0d_dec_phase", i), s_ph,  tbl[i].ph);
            check($sformatf("tbl%0d_out_valid", i), s_ov,  tbl[i].ov);
            check($sformatf("tbl%0d_busy", i),      s_bz,  tbl[i].bz);
            check($sformatf("tbl%0d_cfg_err", i),   s_er,  tbl[i].er);
        end

        // in_valid toggling: phase holds in gaps, comb every 8 cycles, 4 accepts per frame.
        last_ce = -1; ie_cnt = 0; n_ce = 0; prev_iv = 1'b1; prev_ph = '0;
        for (int k = 0; k < 40; k++) begin
            logic iv;
            iv = (k % 2 == 0);
            step(1'b1, iv, 1'b0, '0);
            if (!prev_iv) check("gap_phase_hold", s_ph, prev_ph);
            check("tog_integ_en", s_ie, iv);
            if (s_ce) begin
                if (last_ce >= 0) begin
                    check("tog_comb_period", k - last_ce, 8);
                    check("tog_integ_per_frame", ie_cnt, 4);
                end
                last_ce = k; ie_cnt = 0; n_ce++;
            end
            if (s_ie) ie_cnt++;
            prev_iv = iv; prev_ph = s_ph;
        end
        check("tog_comb_count", n_ce, 5);

        // Disable at dec_phase=2 in RUN, then re-enable and repeat warm-up.
        found = 1'b0;
        for (int w = 0; w < 10 && !found; w++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            if (s_ph == 1) found = 1'b1;
        end
        check("wait_phase1", found, 1);
        step(1'b0, 1'b1, 1'b0, '0);
        check("dis_in_ready", s_rdy, 0);
        check("dis_integ_en", s_ie,  0);
        check("dis_phase",    s_ph,  2);
        check("dis_busy_same_cycle", s_bz, 1);
        step(1'b0, 1'b1, 1'b0, '0);
        check("dis_busy_next",    s_bz, 0);
        check("dis_phase_next",   s_ph, 0);
        check("dis_comb_en_next", s_ce, 0);
        check("dis_out_valid",    s_ov, 0);
        for (int k = 0; k < 22; k++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            check($sformatf("reen%0d_comb_en", k),   s_ce, (k >= 5 && (k - 5) % 4 == 0));
            check($sformatf("reen%0d_out_valid", k), s_ov, (k >= 18 && (k - 18) % 4 == 0));
        end

        // Ratio change to 2 loaded at dec_phase=1: current frame completes with R=4.
        found = 1'b0;
        for (int w = 0; w < 10 && !found; w++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            if (s_ph == 0) found = 1'b1;
        end
        check("wait_phase0", found, 1);
        step(1'b1, 1'b1, 1'b1, RW'(2));
        check("ld2_phase", s_ph, 1);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            check($sformatf("r2_%0d_comb_en", i),   s_ce, (i == 3) || (i >= 5 && i % 2 == 1));
            check($sformatf("r2_%0d_out_valid", i), s_ov, (i >= 4 && i % 2 == 0));
            check($sformatf("r2_%0d_phase", i),     s_ph, (i < 3) ? i + 1 : (i - 3) % 2);
        end

        // Async reset mid-RUN after loading ratio 6; default ratio must return.
        step(1'b1, 1'b1, 1'b1, RW'(6));
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        check("pre_rst_busy", s_bz, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready",  bus.in_ready,  0);
        check("arst_integ_en",  bus.integ_en,  0);
        check("arst_comb_en",   bus.comb_en,   0);
        check("arst_phase",     bus.dec_phase, 0);
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_busy",      bus.busy,      0);
        check("arst_cfg_err",   bus.cfg_err,   0);
        bus.enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 19; k++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            check($sformatf("post_rst%0d_comb_en", k), s_ce, (k >= 5 && (k - 5) % 4 == 0));
            check($sformatf("post_rst%0d_phase", k),   s_ph, (k >= 1) ? (k - 1) % 4 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cic_dec_ctrl.md
Name: cic_dec_ctrl

Overview:
- Sequencing controller for the CIC decimator datapath.
- Generates per-sample enables for the integrator chain, a decimation phase counter, and comb-stage enables once every R accepted samples.
- Tracks comb pipeline warm-up and qualifies decimated output validity.
- Holds a run-time programmable decimation ratio. The ratio changes only on frame boundaries.

Parameters:
NUM_STAGES, 3, number of integrator/comb stage pairs; sets warm-up length in comb pulses
RATIO_WIDTH, 5, width of decimation ratio and phase counter
DEFAULT_RATIO, 4, ratio loaded into shadow and active registers at reset (must be >= 2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  run request; level-sensitive
cfg_ratio  in  RATIO_WIDTH  requested decimation ratio R
cfg_load  in  1  one-cycle strobe; writes cfg_ratio to shadow register
in_valid  in  1  input sample present at integrator input
in_ready  out  1  controller accepting samples
integ_en  out  1  integrator chain enable; one per accepted sample
comb_en  out  1  comb chain enable pulse; one per decimated sample
dec_phase  out  RATIO_WIDTH  current phase within frame, 0..R-1
out_valid  out  1  decimated output valid pulse
busy  out  1  controller not in IDLE
cfg_err  out  1  one-cycle pulse when a rejected ratio is loaded

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - All outputs 0, dec_phase=0, warm count=0.
  - Shadow and active ratio = DEFAULT_RATIO.
- States: IDLE, WARMUP, RUN.
  - IDLE -> WARMUP: enable=1. Active ratio loaded from shadow; phase and warm count cleared.
  - WARMUP -> RUN: in the cycle the NUM_STAGES-th comb_en is issued.
  - WARMUP/RUN -> IDLE: on the cycle after enable=0 is sampled.
- in_ready is combinational: (state != IDLE) && enable.
  - integ_en = in_valid && in_ready, same cycle. Zero latency; the integrators register the sample on that edge.
- Phase counter:
  - Increments on each accept and holds while in_valid=0.
  - On an accept with phase == active R-1: phase wraps to 0, and comb_en is registered high for exactly the next cycle (latency 1 from the last accept of the frame).
- Warm count increments on each comb_en and saturates at NUM_STAGES.
  - out_valid is registered: it pulses the cycle after a comb_en, only when that comb_en was pulse number > NUM_STAGES since entering WARMUP.
- Config:
  - cfg_load with cfg_ratio < 2: cfg_err pulses the next cycle; shadow is unchanged.
  - Otherwise shadow <= cfg_ratio.
  - Active ratio reloads from shadow only at phase wrap or on IDLE->WARMUP.
  - cfg_load coinciding with a wrap: the wrap uses the old shadow; the new value takes effect at the following wrap.
  - A ratio change never restarts warm-up.
- Disable mid-operation:
  - in_ready drops combinationally in the same cycle.
  - On entering IDLE: comb_en and out_valid are forced 0, phase and warm count are cleared, busy=0.
  - A partial frame is discarded.
  - Re-enable repeats the full warm-up.
- busy = (state != IDLE), registered with the state.
- Width: ratio is unsigned; max R = 2^RATIO_WIDTH - 1. Phase compare is against R-1 with no overflow.

Test Plan:
- Params 3/5/4, reset, enable=1 at cycle 0, in_valid=1 continuous.
  - Required: in_ready/integ_en high from cycle 1; comb_en at cycles 5, 9, 13, 17.
  - Required: RUN entered at cycle 13; out_valid first at 18, then 22, 26.
- in_valid toggling 1/0 each cycle in RUN.
  - Required: dec_phase holds during gaps; comb_en every 8 cycles; integ_en count between comb pulses = 4.
- cfg_load cfg_ratio=2 at dec_phase=1.
  - Required: current frame finishes with R=4; subsequent comb_en every 2 accepted samples; no extra warm-up; out_valid uninterrupted.
- cfg_load cfg_ratio=1, then cfg_ratio=0.
  - Required: cfg_err pulses one cycle each; comb period stays 4.
- enable=0 at dec_phase=2 in RUN.
  - Required: in_ready=0 same cycle; next cycle busy=0, dec_phase=0, no comb_en/out_valid.
  - Re-enable: first 3 comb_en give no out_valid.
- rst_n low mid-RUN after cfg_load 6.
  - Required: all outputs 0 immediately, asynchronously.
  - Required: after release and enable, comb period = 4 (DEFAULT_RATIO).
